// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//
// SPI (mode 0) peripheral that writes a bank of five 8-bit control registers.
// A frame is 16 bits, MSB first: {rw, addr[6:0], data[7:0]}, rw = 1 for write.
// sclk, copi and ncs are asynchronous to clk and are resynchronized with
// SYNC_STAGES flops before edge detection.
//
// Optional feature: define SPI_READBACK_EN to let rw = 0 frames return the
// addressed register on cipo during the data byte. Without it cipo is tied 0
// and read frames are dropped.
//
// Parameters
//   SYNC_STAGES  synchronizer depth for sclk/copi/ncs (2..3)
//   MAX_ADDR     highest writable register address
//
// Ports
//   clk, rst_n         system clock, async active-low reset
//   sclk, copi, ncs    SPI pins from the controller
//   cipo               SPI read data (readback builds only)
//   en_reg_out_7_0     reg 0x00      en_reg_out_15_8   reg 0x01
//   en_reg_pwm_7_0     reg 0x02      en_reg_pwm_15_8   reg 0x03
//   pwm_duty_cycle     reg 0x04
//   txn_done           one-clk pulse per committed write
//   dbg_state          current FSM state (IDLE=0, SHIFT=1, COMMIT=2)
//
// Handshake: there is no valid/ready pair here; txn_done is a single-cycle
// strobe asserted on the same clk edge that updates the addressed register.
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       txn_done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] MAX_A  = 7'(MAX_ADDR);
    // Cycles after reset until the synchronizers and edge flops hold real pin
    // values rather than their reset preload.
    localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_q, ncs_q;
    logic [2:0]             settle_cnt;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   edges_ok;
    logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic        frame_ok;
    logic        frame_start;
    logic        commit_write;

    // ------------------------------------------------------------------
    // Synchronizers. ncs preloads to 1 and sclk to 0 (their idle levels)
    // so reset release does not look like an edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync  <= '0;
            copi_sync  <= '0;
            ncs_sync   <= '1;
            sclk_q     <= 1'b0;
            ncs_q      <= 1'b1;
            settle_cnt <= SETTLE;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
            ncs_q     <= ncs_sync[SYNC_STAGES-1];
            if (settle_cnt != 3'd0) begin
                settle_cnt <= settle_cnt - 3'd1;
            end
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync[SYNC_STAGES-1];

    // If ncs is held low through reset, the preloaded 1 would drain out and
    // fake a falling edge; edges are ignored until the pipeline has settled,
    // so the first frame needs a genuine fall of ncs.
    assign edges_ok  = (settle_cnt == 3'd0);
    assign sclk_rise = edges_ok &  sclk_s & ~sclk_q;
    assign sclk_fall = edges_ok & ~sclk_s &  sclk_q;
    assign ncs_rise  = edges_ok &  ncs_s  & ~ncs_q;
    assign ncs_fall  = edges_ok & ~ncs_s  &  ncs_q;

    // A frame is accepted only with exactly 16 bits, write flag and an
    // address inside the register bank.
    assign frame_ok = (bit_cnt == 5'd16) && shift_reg[15] && (shift_reg[14:8] <= MAX_A);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        frame_start  = 1'b0;
        commit_write = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall) begin
                    state_next  = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit_write = frame_ok;
                // A new select arriving during the commit cycle starts the
                // next frame straight away.
                if (ncs_fall) begin
                    state_next  = SHIFT;
                    frame_start = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Shift register and saturating bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 5'd0;
            shift_reg <= 16'h0000;
        end else if (frame_start) begin
            bit_cnt   <= 5'd0;
            shift_reg <= 16'h0000;
        end else if ((state == SHIFT) && sclk_rise && (bit_cnt != 5'd16)) begin
            shift_reg <= {shift_reg[14:0], copi_s};
            bit_cnt   <= bit_cnt + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            txn_done        <= 1'b0;
        end else begin
            txn_done <= commit_write;
            if (commit_write) begin
                case (shift_reg[14:8])
                    7'd0:    en_reg_out_7_0  <= shift_reg[7:0];
                    7'd1:    en_reg_out_15_8 <= shift_reg[7:0];
                    7'd2:    en_reg_pwm_7_0  <= shift_reg[7:0];
                    7'd3:    en_reg_pwm_15_8 <= shift_reg[7:0];
                    7'd4:    pwm_duty_cycle  <= shift_reg[7:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_READBACK_EN
    // ------------------------------------------------------------------
    // Readback. Once the header byte is in (bit_cnt == 8) shift_reg[7:0]
    // holds {rw, addr}; the selected byte is latched and driven MSB first on
    // successive sclk falls so the controller samples it on the rises.
    // ------------------------------------------------------------------
    logic [7:0] rd_sel;
    logic [7:0] rd_byte;

    always_comb begin
        rd_sel = 8'h00;
        if (!shift_reg[7] && (shift_reg[6:0] <= MAX_A)) begin
            case (shift_reg[6:0])
                7'd0:    rd_sel = en_reg_out_7_0;
                7'd1:    rd_sel = en_reg_out_15_8;
                7'd2:    rd_sel = en_reg_pwm_7_0;
                7'd3:    rd_sel = en_reg_pwm_15_8;
                7'd4:    rd_sel = pwm_duty_cycle;
                default: rd_sel = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipo    <= 1'b0;
            rd_byte <= 8'h00;
        end else if (state != SHIFT) begin
            cipo <= 1'b0;
        end else if (sclk_fall) begin
            if (bit_cnt == 5'd8) begin
                rd_byte <= rd_sel;
                cipo    <= rd_sel[7];
            end else if ((bit_cnt > 5'd8) && (bit_cnt < 5'd16)) begin
                // bit_cnt 9..15 -> data bit 6..0
                cipo <= rd_byte[3'd7 - bit_cnt[2:0]];
            end else begin
                cipo <= 1'b0;
            end
        end
    end
`else
    assign cipo = 1'b0;
`endif

endmodule
